// File: rtl/imm_ext_pipe.sv
// Immediate generator for the ARMv8 datapath. The instruction is decoded into an
// extended immediate at the input, then delivered over valid/ready through an
// output register backed by a one-entry skid register.
module imm_ext_pipe #(
   parameter int DATA_W    = 64,
   parameter int ERR_CNT_W = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [31:0]          in_inst,
   input  logic [2:0]           in_mode,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [DATA_W-1:0]    out_imm,
   output logic                 out_err,
   output logic [ERR_CNT_W-1:0] err_count
);

   logic [63:0]          ext_full;
   logic [DATA_W-1:0]    ext_imm;
   logic                 ext_illegal;
   logic                 accept;
   logic                 deliver;

   logic                 o_valid_q, o_valid_d;
   logic [DATA_W-1:0]    o_imm_q,   o_imm_d;
   logic                 o_err_q,   o_err_d;
   logic                 s_valid_q, s_valid_d;
   logic [DATA_W-1:0]    s_imm_q,   s_imm_d;
   logic                 s_err_q,   s_err_d;
   logic [ERR_CNT_W-1:0] cnt_q,     cnt_d;

   // Decode and extend the immediate field; built at 64 bits then cut to DATA_W.
   always_comb begin
      ext_full    = '0;
      ext_illegal = 1'b0;
      unique case (in_mode)
         3'b000: ext_full = {52'b0, in_inst[21:10]};
         3'b001: ext_full = {{55{in_inst[20]}}, in_inst[20:12]};
         3'b010: ext_full = {{36{in_inst[25]}}, in_inst[25:0], 2'b00};
         3'b011: ext_full = {{43{in_inst[23]}}, in_inst[23:5], 2'b00};
         3'b100: ext_full = {52'b0, in_inst[21:10]} << (in_inst[22] ? 6'd12 : 6'd0);
         3'b101: begin
            ext_full    = {48'b0, in_inst[20:5]} << {in_inst[22:21], 4'b0000};
            // A 32/48-bit MOVZ shift has no meaning on a 32-bit datapath
            ext_illegal = (DATA_W == 32) && in_inst[22];
         end
         3'b110: ext_full = {52'b0, in_inst[21:10]} << in_inst[31:30];
         default: ext_illegal = 1'b1;
      endcase
      if (ext_illegal) begin
         ext_full = '0;
      end
   end

   assign ext_imm  = ext_full[DATA_W-1:0];
   assign in_ready = ~s_valid_q;
   assign accept   = in_valid & in_ready;
   assign deliver  = o_valid_q & out_ready;

   // Output/skid steering: skid drains into output first, otherwise new data fills
   // the output when it frees up this cycle, else parks in the skid register.
   always_comb begin
      o_valid_d = o_valid_q;
      o_imm_d   = o_imm_q;
      o_err_d   = o_err_q;
      s_valid_d = s_valid_q;
      s_imm_d   = s_imm_q;
      s_err_d   = s_err_q;
      if (deliver && s_valid_q) begin
         o_valid_d = 1'b1;
         o_imm_d   = s_imm_q;
         o_err_d   = s_err_q;
         s_valid_d = 1'b0;
      end else if (accept && (!o_valid_q || deliver)) begin
         o_valid_d = 1'b1;
         o_imm_d   = ext_imm;
         o_err_d   = ext_illegal;
      end else if (accept) begin
         s_valid_d = 1'b1;
         s_imm_d   = ext_imm;
         s_err_d   = ext_illegal;
      end else if (deliver) begin
         o_valid_d = 1'b0;
      end
   end

   // Saturating count of accepted illegal requests.
   always_comb begin
      cnt_d = cnt_q;
      if (accept && ext_illegal && (cnt_q != '1)) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   // State registers; reset discards any in-flight results.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         o_valid_q <= 1'b0;
         o_imm_q   <= '0;
         o_err_q   <= 1'b0;
         s_valid_q <= 1'b0;
         s_imm_q   <= '0;
         s_err_q   <= 1'b0;
         cnt_q     <= '0;
      end else begin
         o_valid_q <= o_valid_d;
         o_imm_q   <= o_imm_d;
         o_err_q   <= o_err_d;
         s_valid_q <= s_valid_d;
         s_imm_q   <= s_imm_d;
         s_err_q   <= s_err_d;
         cnt_q     <= cnt_d;
      end
   end

   assign out_valid = o_valid_q;
   assign out_imm   = o_imm_q;
   assign out_err   = o_err_q;
   assign err_count = cnt_q;

endmodule

// File: tb/tb_imm_ext_pipe.sv
// Bench for imm_ext_pipe: a 64-bit instance and a 32-bit instance with a 2-bit
// error counter share one stimulus stream; expected results are queued on accept
// and popped on delivery.
module tb_imm_ext_pipe;

   typedef struct {
      logic [63:0] imm;
      logic        err;
   } exp_t;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic [31:0] in_inst;
   logic [2:0]  in_mode;
   logic        out_ready;

   logic        in_ready64, out_valid64, out_err64;
   logic [63:0] out_imm64;
   logic [7:0]  err_count64;
   logic        in_ready32, out_valid32, out_err32;
   logic [31:0] out_imm32;
   logic [1:0]  err_count32;

   int errors = 0;
   int checks = 0;

   exp_t q64[$];
   exp_t q32[$];
   int   exp_cnt64 = 0;
   int   exp_cnt32 = 0;

   logic        prev_stall64 = 1'b0, prev_stall32 = 1'b0;
   logic [63:0] prev_imm64;
   logic [31:0] prev_imm32;
   logic        prev_err64, prev_err32;

   imm_ext_pipe #(.DATA_W(64), .ERR_CNT_W(8)) u64 (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready64), .in_inst(in_inst), .in_mode(in_mode),
      .out_valid(out_valid64), .out_ready(out_ready), .out_imm(out_imm64),
      .out_err(out_err64), .err_count(err_count64)
   );

   imm_ext_pipe #(.DATA_W(32), .ERR_CNT_W(2)) u32 (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready32), .in_inst(in_inst), .in_mode(in_mode),
      .out_valid(out_valid32), .out_ready(out_ready), .out_imm(out_imm32),
      .out_err(out_err32), .err_count(err_count32)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference decode, written arithmetically rather than bit-by-bit.
   function automatic exp_t model(input logic [31:0] i, input logic [2:0] m, input int w);
      exp_t r;
      r.imm = '0;
      r.err = 1'b0;
      case (m)
         3'd0: r.imm = 64'(i[21:10]);
         3'd1: r.imm = 64'($signed(i[20:12]));
         3'd2: r.imm = 64'($signed({i[25:0], 2'b00}));
         3'd3: r.imm = 64'($signed({i[23:5], 2'b00}));
         3'd4: r.imm = 64'(i[21:10]) * (i[22] ? 64'd4096 : 64'd1);
         3'd5: begin
            r.imm = 64'(i[20:5]) * (64'd1 << (16 * int'(i[22:21])));
            if (w == 32 && i[22]) r.err = 1'b1;
         end
         3'd6: r.imm = 64'(i[21:10]) * (64'd1 << i[31:30]);
         default: r.err = 1'b1;
      endcase
      if (r.err) r.imm = '0;
      if (w == 32) r.imm = r.imm & 64'h0000_0000_FFFF_FFFF;
      return r;
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // One clock: check outputs against the scoreboard, queue accepted requests,
   // then advance to the next falling edge.
   task automatic cycle();
      exp_t e;
      if (out_valid64) begin
         if (prev_stall64) begin
            chk("stable_imm64", out_imm64, prev_imm64);
            chk("stable_err64", 64'(out_err64), 64'(prev_err64));
         end
         if (out_ready) begin
            if (q64.size() == 0) chk("spurious64", 64'(out_valid64), 64'd0);
            else begin
               e = q64.pop_front();
               chk("imm64", out_imm64, e.imm);
               chk("err64", 64'(out_err64), 64'(e.err));
            end
         end
      end
      if (out_valid32) begin
         if (prev_stall32) chk("stable_imm32", 64'(out_imm32), 64'(prev_imm32));
         if (out_ready) begin
            if (q32.size() == 0) chk("spurious32", 64'(out_valid32), 64'd0);
            else begin
               e = q32.pop_front();
               chk("imm32", 64'(out_imm32), e.imm);
               chk("err32", 64'(out_err32), 64'(e.err));
            end
         end
      end
      prev_stall64 = out_valid64 & ~out_ready;
      prev_imm64   = out_imm64;
      prev_err64   = out_err64;
      prev_stall32 = out_valid32 & ~out_ready;
      prev_imm32   = out_imm32;
      prev_err32   = out_err32;
      if (in_valid && in_ready64) begin
         e = model(in_inst, in_mode, 64);
         q64.push_back(e);
         if (e.err && exp_cnt64 < 255) exp_cnt64++;
      end
      if (in_valid && in_ready32) begin
         e = model(in_inst, in_mode, 32);
         q32.push_back(e);
         if (e.err && exp_cnt32 < 3) exp_cnt32++;
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic send(input logic [31:0] inst, input logic [2:0] mode);
      in_valid = 1'b1;
      in_inst  = inst;
      in_mode  = mode;
      cycle();
   endtask

   task automatic drain();
      int n = 0;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      while ((q64.size() != 0 || q32.size() != 0) && n < 20) begin
         cycle();
         n++;
      end
      cycle();
      chk("drain_empty", 64'(q64.size() + q32.size()), 64'd0);
   endtask

   initial begin
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_inst   = '0;
      in_mode   = '0;
      out_ready = 1'b0;
      @(negedge clk);
      chk("rst_ready64", 64'(in_ready64), 64'd1);
      chk("rst_valid64", 64'(out_valid64), 64'd0);
      chk("rst_imm64", out_imm64, 64'd0);
      chk("rst_err64", 64'(out_err64), 64'd0);
      chk("rst_cnt64", 64'(err_count64), 64'd0);
      chk("rst_valid32", 64'(out_valid32), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // Directed vectors for every mode, streaming with out_ready high.
      out_ready = 1'b1;
      send(32'hFFF << 10, 3'b000);
      chk("lat1_valid", 64'(out_valid64), 64'd1);
      chk("mode0_fff", out_imm64, 64'h0000_0000_0000_0FFF);
      send(32'h1FF << 12, 3'b001);
      send(32'h200_0000, 3'b010);
      send(32'h1 << 5, 3'b011);
      send((32'h1234 << 5) | (32'h3 << 21), 3'b101);
      send((32'h1 << 22) | (32'h001 << 10), 3'b100);
      send((32'h3 << 30) | (32'h002 << 10), 3'b110);
      send((32'h1234 << 5) | (32'h1 << 21), 3'b101);
      drain();

      // Illegal requests: 64-bit counter tracks, 2-bit counter saturates.
      for (int k = 0; k < 5; k++) send($urandom, 3'b111);
      drain();
      chk("errcnt64", 64'(err_count64), 64'(exp_cnt64));
      chk("errcnt32_sat", 64'(err_count32), 64'(exp_cnt32));
      chk("errcnt32_is3", 64'(err_count32), 64'd3);

      // Backpressure: A, B fill output and skid, C is held off.
      out_ready = 1'b0;
      send(32'h0000_0400, 3'b000);
      send(32'h0000_0800, 3'b000);
      chk("stall_ready0", 64'(in_ready64), 64'd0);
      for (int k = 0; k < 3; k++) send(32'h0000_0C00, 3'b000);
      chk("stall_queued", 64'(q64.size()), 64'd2);
      out_ready = 1'b1;
      for (int k = 0; k < 10 && q64.size() < 3; k++) send(32'h0000_0C00, 3'b000);
      drain();

      // Random traffic with random backpressure.
      for (int k = 0; k < 120; k++) begin
         in_valid  = 1'($urandom);
         in_inst   = $urandom;
         in_mode   = 3'($urandom_range(0, 7));
         out_ready = 1'($urandom);
         cycle();
      end
      drain();
      chk("errcnt64_rand", 64'(err_count64), 64'(exp_cnt64));
      chk("errcnt32_rand", 64'(err_count32), 64'(exp_cnt32));

      // Asynchronous reset with both registers full.
      out_ready = 1'b0;
      send(32'hFFFF_FFFF, 3'b111);
      send(32'h0000_0400, 3'b000);
      in_valid = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      chk("arst_valid64", 64'(out_valid64), 64'd0);
      chk("arst_cnt64", 64'(err_count64), 64'd0);
      chk("arst_imm64", out_imm64, 64'd0);
      chk("arst_ready64", 64'(in_ready64), 64'd1);
      chk("arst_cnt32", 64'(err_count32), 64'd0);
      q64.delete();
      q32.delete();
      exp_cnt64    = 0;
      exp_cnt32    = 0;
      prev_stall64 = 1'b0;
      prev_stall32 = 1'b0;
      @(negedge clk);
      rst_n     = 1'b1;
      out_ready = 1'b1;
      @(negedge clk);
      send(32'h0000_1400, 3'b000);
      chk("post_rst_lat1", 64'(out_valid64), 64'd1);
      drain();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
